change_logger: RTL
==================

# change_logger

Hardware counterpart of the bench-side `$monitor`. It samples a probe bus on every rising clock edge while armed and records a `{timestamp, value}` entry each time the value changes. The first sample after arming is always recorded. Entries are buffered in a small FIFO and drained through a valid/ready read port. It sits beside the MIPS datapath as a debug tap, for example on a pipeline register or control signal, and is read out by a host or checker.

## Interface
Parameters:
- `WIDTH`, 4: probe bus width.
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 8: FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- `clk`, in, 1: single clock; all logic samples on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `arm`, in, 1: level; capture is enabled while high.
- `probe`, in, WIDTH: observed signal.
- `rd_ready`, in, 1: consumer accepts the head entry.
- `rd_valid`, out, 1: FIFO is not empty.
- `rd_value`, out, WIDTH: head entry probe value.
- `rd_time`, out, TS_W: head entry timestamp.
- `count`, out, clog2(DEPTH)+1: number of occupied entries.
- `overflow`, out, 1: sticky flag; at least one entry was dropped.
- `armed`, out, 1: registered copy of `arm`.

## Operation
- **Reset (`rst`=1 at an edge):**
  - `armed`=0, `rd_valid`=0, `count`=0, `overflow`=0.
  - Timestamp = 0, `last_value` = 0, `first` = 1.
  - FIFO pointers = 0; `rd_value`/`rd_time` are don't-care while `rd_valid`=0.
  - Reset overrides every other input on that edge, including in-flight captures and pops.
- **Arm rising edge** (`arm`=1, `armed`=0):
  - Timestamp loads 0, `first` is set, `overflow` clears.
  - Existing FIFO contents are kept.
  - The capture decision on this same edge uses timestamp value 0 and `first`=1, so an entry `{0, probe}` is pushed.
- **While armed:**
  - Timestamp increments by 1 each cycle and wraps from 2^TS_W−1 to 0. No wrap marker is logged.
  - Push condition: `first` OR `probe != last_value`.
  - On push: `last_value <= probe`, `first <= 0`.
- **Disarmed** (`arm`=0): no pushes; timestamp holds; the read port keeps draining.
- **Pop:** occurs when `rd_valid && rd_ready`. The FIFO is first-word fall-through, so head data is valid in the same cycle as `rd_valid`.
- **Boundary conditions:**
  - Full with push and no pop: entry is dropped, `overflow` <= 1, and `last_value` still updates, so the next logged change is relative to the dropped value.
  - Full with push and pop on the same edge: both happen; `count` is unchanged and `overflow` is not set.
  - Empty with pop request: ignored because `rd_valid`=0.
  - Push and pop together when `count`=1: the new entry becomes the head next cycle; `count` stays 1.
  - `rd_ready` high with `rd_valid` low has no effect.

## Timing
- Capture latency: a change present at edge N is pushed at edge N; `rd_valid` rises after edge N, visible in cycle N+1 if the FIFO was empty.
- Recorded timestamp = counter value before the increment at edge N. The first entry after arming always carries time 0.
- `count`, `overflow`, `armed` and `rd_valid` are registered outputs; `rd_value`/`rd_time` are read combinationally from the FIFO head.
- Throughput: 1 push and 1 pop per cycle.

## Structure
- **Shared package `logger_pkg`:**
  - `ENTRY_W(WIDTH,TS_W)` = TS_W+WIDTH.
  - Entry packing: timestamp in the MSBs, value in the LSBs.
  - `clog2` function for pointer and `count` widths.
- **Sub-module `sync_fifo`:**
  - Parameters `W`, `DEPTH`; ports `clk`/`rst`, push/pop, full/empty, count, FWFT head.
  - Pointers carry an extra wrap bit for the full/empty distinction.
- **Top:** arm edge detect, timestamp counter, `last_value`/`first` registers, push gating and overflow logic.

## Test plan
- Reset, then `arm`=1 with `probe`=4'h3 held 5 cycles, `rd_ready`=0 → exactly one entry `{0, 3}`; `count`=1; `rd_valid`=1 from the cycle after arming.
- Armed; `probe` goes 3 at t0, 5 at t2, 5 at t3, 0 at t4 → entries `{0,3}`, `{2,5}`, `{4,0}`; no entry at t3.
- `DEPTH`=8, `rd_ready`=0, probe toggles every cycle for 10 cycles → `count`=8, `overflow`=1, entries hold t0..t7; then drain with `rd_ready`=1 → 8 pops in order, `rd_valid`=0 afterwards, `overflow` still 1.
- FIFO full, push and pop on the same edge → `count` stays 8, `overflow` stays 0, head advances, and the newest entry is at the tail.
- `TS_W`=4, probe changes at cycles 14 and 17 after arming → timestamps 14 and 1 (wrapped).
- Mid-capture `rst`=1 with 3 entries queued and `arm`=1 → next cycle `count`=0, `rd_valid`=0, `armed`=0. Keeping `arm`=1 re-arms on the following edge and logs `{0, probe}`.

Source files
------------

// File: rtl/logger_pkg.sv
// +------------------------------------------------------------------+
// | logger_pkg : shared sizing helpers for change_logger             |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
`default_nettype none

package logger_pkg;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Entry layout: {timestamp, value}, timestamp in the MSBs.
  function automatic int ENTRY_W(input int width, input int ts_w);
    return ts_w + width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +------------------------------------------------------------------+
// | sync_fifo : first-word fall-through FIFO with wrap-bit pointers  |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
`default_nettype none

module sync_fifo
  import logger_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count,
  output logic [W-1:0]            rd_data
);

  localparam int          AW      = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count    = wr_ptr_q - rd_ptr_q;
    do_pop   = pop && !empty;
    // A pop on the same edge frees the slot a full-FIFO push needs.
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/change_logger.sv
// +------------------------------------------------------------------+
// | change_logger : logs {timestamp, value} on each probe change      |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
`default_nettype none

module change_logger
  import logger_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic [WIDTH-1:0]       probe,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_value,
  output logic [TS_W-1:0]        rd_time,
  output logic [clog2(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   armed
);

  localparam int            LW     = ENTRY_W(WIDTH, TS_W);
  localparam logic [TS_W-1:0] TS_ONE = {{(TS_W-1){1'b0}}, 1'b1};

  logic             armed_q, armed_d;
  logic             first_q, first_d;
  logic             overflow_q, overflow_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [WIDTH-1:0] last_q, last_d;

  logic             arm_rise;
  logic             eff_first;
  logic [TS_W-1:0]  eff_ts;
  logic             want_push;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    head;

  always_comb begin
    arm_rise   = arm && !armed_q;
    // On the arming edge the capture sees a freshly cleared timestamp/first.
    eff_first  = arm_rise || first_q;
    eff_ts     = arm_rise ? '0 : ts_q;
    want_push  = arm && (eff_first || (probe != last_q));

    armed_d    = arm;
    ts_d       = arm ? eff_ts + TS_ONE : ts_q;
    last_d     = want_push ? probe : last_q;
    first_d    = want_push ? 1'b0 : eff_first;
    overflow_d = (arm_rise ? 1'b0 : overflow_q) |
                 (want_push && fifo_full && !rd_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q    <= 1'b0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
      ts_q       <= '0;
      last_q     <= '0;
    end else begin
      armed_q    <= armed_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
      ts_q       <= ts_d;
      last_q     <= last_d;
    end
  end

  sync_fifo #(
    .W     (LW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (want_push),
    .pop     (rd_ready),
    .wr_data ({eff_ts, probe}),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count),
    .rd_data (head)
  );

  always_comb begin
    rd_valid = !fifo_empty;
    rd_time  = head[LW-1:WIDTH];
    rd_value = head[WIDTH-1:0];
    overflow = overflow_q;
    armed    = armed_q;
  end

endmodule

`default_nettype wire
